// File: rtl/ysyx_22041211_ifu_pkg.sv
// Shared types and constants for the ysyx_22041211 instruction fetch unit:
// FSM encodings, default reset PC, the canonical NOP and small address helpers.
package ysyx_22041211_ifu_pkg;

   typedef enum logic [1:0] {
      IFU_S_REQ   = 2'd0,
      IFU_S_WAIT  = 2'd1,
      IFU_S_HOLD  = 2'd2,
      IFU_S_FAULT = 2'd3
   } ifu_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   // addi x0, x0, 0; shown in place of bubbles by simulation tooling
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

   // Jump wins over a taken branch when the decoder asserts both.
   function automatic logic [31:0] select_next_pc(
      input logic [31:0] pc,
      input logic        jmp_flag,
      input logic [31:0] jmp_target,
      input logic        branch_taken,
      input logic [31:0] branch_target
   );
      if (jmp_flag)
         return jmp_target;
      else if (branch_taken)
         return branch_target;
      else
         return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: owns the PC, issues one outstanding fetch at a time and
// holds {inst, pc} for the decoder until accepted; faults are sticky until reset.
module ysyx_22041211_ifu
   import ysyx_22041211_ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid_o,
   output logic [31:0] imem_req_addr_o,
   input  logic        imem_req_ready_i,
   input  logic        imem_resp_valid_i,
   input  logic [31:0] imem_resp_data_i,
   input  logic        imem_resp_err_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   input  logic        jmp_flag_i,
   input  logic [31:0] jmp_target_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   output logic        fault_o,
   output logic [31:0] fault_pc_o,
   output logic [31:0] fetch_cnt_o
);

   ifu_state_e  state_q;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic [31:0] fault_pc_q;
   logic [31:0] fetch_cnt_q;
   logic [31:0] next_pc_d;

   always_comb begin
      next_pc_d = select_next_pc(pc_q, jmp_flag_i, jmp_target_i,
                                 branch_taken_i, branch_target_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IFU_S_REQ;
         pc_q        <= RESET_PC;
         inst_q      <= 32'd0;
         fault_pc_q  <= 32'd0;
         fetch_cnt_q <= 32'd0;
      end else begin
         case (state_q)
            IFU_S_REQ: begin
               if (imem_req_ready_i)
                  state_q <= IFU_S_WAIT;
            end
            IFU_S_WAIT: begin
               if (imem_resp_valid_i) begin
                  if (imem_resp_err_i) begin
                     fault_pc_q <= pc_q;
                     state_q    <= IFU_S_FAULT;
                  end else begin
                     inst_q  <= imem_resp_data_i;
                     state_q <= IFU_S_HOLD;
                  end
               end
            end
            IFU_S_HOLD: begin
               if (inst_ready_i) begin
                  fetch_cnt_q <= fetch_cnt_q + 32'd1;
                  // A misaligned target leaves pc_q pointing at the accepted instruction.
                  if (is_misaligned(next_pc_d)) begin
                     fault_pc_q <= next_pc_d;
                     state_q    <= IFU_S_FAULT;
                  end else begin
                     pc_q    <= next_pc_d;
                     state_q <= IFU_S_REQ;
                  end
               end
            end
            IFU_S_FAULT: begin
               state_q <= IFU_S_FAULT;
            end
            default: begin
               state_q <= IFU_S_FAULT;
            end
         endcase
      end
   end

   assign imem_req_valid_o = (state_q == IFU_S_REQ);
   assign imem_req_addr_o  = pc_q;
   assign inst_valid_o     = (state_q == IFU_S_HOLD);
   assign fault_o          = (state_q == IFU_S_FAULT);
   assign inst_o           = inst_q;
   assign pc_o             = pc_q;
   assign fault_pc_o       = fault_pc_q;
   assign fetch_cnt_o      = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Scoreboard bench for the fetch unit: a memory/decoder driver with a PC model pushes
// expected requests, instructions and faults; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ysyx_22041211_ifu;
   import ysyx_22041211_ifu_pkg::*;

   localparam logic [31:0] RPC = RESET_PC_DEFAULT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid_o;
   logic [31:0] imem_req_addr_o;
   logic        imem_req_ready_i  = 1'b0;
   logic        imem_resp_valid_i = 1'b0;
   logic [31:0] imem_resp_data_i  = 32'd0;
   logic        imem_resp_err_i   = 1'b0;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        inst_valid_o;
   logic        inst_ready_i      = 1'b0;
   logic        jmp_flag_i        = 1'b0;
   logic [31:0] jmp_target_i      = 32'd0;
   logic        branch_taken_i    = 1'b0;
   logic [31:0] branch_target_i   = 32'd0;
   logic        fault_o;
   logic [31:0] fault_pc_o;
   logic [31:0] fetch_cnt_o;

   ysyx_22041211_ifu #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
      .imem_req_ready_i(imem_req_ready_i), .imem_resp_valid_i(imem_resp_valid_i),
      .imem_resp_data_i(imem_resp_data_i), .imem_resp_err_i(imem_resp_err_i),
      .inst_o(inst_o), .pc_o(pc_o), .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
      .jmp_flag_i(jmp_flag_i), .jmp_target_i(jmp_target_i),
      .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
      .fault_o(fault_o), .fault_pc_o(fault_pc_o), .fetch_cnt_o(fetch_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] inst; logic [31:0] cnt; } inst_exp_t;
   typedef struct { logic [31:0] fpc; logic [31:0] pc; logic [31:0] cnt; } fault_exp_t;

   logic [31:0] req_q[$];
   inst_exp_t   inst_q[$];
   fault_exp_t  fault_q[$];

   // Knobs, written only by the main sequence.
   int ready_pct = 100, accept_pct = 100, err_pct = 0;
   int min_delay = 1, max_delay = 1, min_hold = 0, mode = 3;
   bit data_nop = 1'b1, stale_en = 1'b0;

   // Reference model state, owned by the driver.
   logic [31:0] exp_pc, exp_cnt, pend_addr, tgt, rnd, rdata;
   bit busy, model_fault, pend, rst_prev;
   int pend_wait, hold_len;

   // Driver: inputs change 2ns after each rising edge and hold through the next one,
   // so any handshake decided here takes effect on the following edge.
   always @(posedge clk) begin
      #2;
      imem_resp_valid_i = 1'b0;
      imem_resp_err_i   = 1'b0;
      imem_resp_data_i  = $urandom;
      if (rst) begin
         exp_pc = RPC; exp_cnt = 32'd0; busy = 1'b0; model_fault = 1'b0;
         pend = 1'b0; pend_wait = 0; hold_len = 0;
         req_q.delete(); inst_q.delete(); fault_q.delete();
         imem_req_ready_i = 1'b0; inst_ready_i = 1'b0;
         jmp_flag_i = 1'b0; branch_taken_i = 1'b0;
      end else begin
         if (rst_prev && stale_en) begin
            imem_resp_valid_i = 1'b1;
         end else if (pend) begin
            if (pend_wait == 0) begin
               rdata = data_nop ? INST_NOP : $urandom;
               imem_resp_valid_i = 1'b1;
               imem_resp_data_i  = rdata;
               pend = 1'b0;
               if ($urandom_range(0, 99) < err_pct) begin
                  imem_resp_err_i = 1'b1;
                  model_fault = 1'b1;
                  fault_q.push_back('{fpc: pend_addr, pc: pend_addr, cnt: exp_cnt});
               end else begin
                  inst_q.push_back('{pc: pend_addr, inst: rdata, cnt: exp_cnt});
               end
            end else begin
               pend_wait--;
            end
         end

         imem_req_ready_i = ($urandom_range(0, 99) < ready_pct);
         if (imem_req_valid_o && imem_req_ready_i && !busy && !model_fault) begin
            req_q.push_back(exp_pc);
            pend = 1'b1; pend_addr = exp_pc; busy = 1'b1;
            pend_wait = $urandom_range(max_delay, min_delay) - 1;
         end

         hold_len = inst_valid_o ? hold_len + 1 : 0;
         inst_ready_i = (hold_len > min_hold) && ($urandom_range(0, 99) < accept_pct);
         rnd = $urandom;
         jmp_target_i = $urandom; branch_target_i = $urandom;
         jmp_flag_i = 1'b0; branch_taken_i = 1'b0;
         case (mode)
            0: begin
               jmp_flag_i = ($urandom_range(0, 3) == 0);
               branch_taken_i = ($urandom_range(0, 2) == 0);
               jmp_target_i = {RPC[31:16], rnd[15:2], 2'b00};
               branch_target_i = {RPC[31:16], rnd[31:18], 2'b00};
            end
            1: begin
               jmp_flag_i = 1'b1; jmp_target_i = 32'h8000_0100;
               branch_taken_i = 1'b1; branch_target_i = 32'h8000_0200;
            end
            2: begin branch_taken_i = 1'b1; branch_target_i = 32'h8000_0102; end
            5: begin jmp_flag_i = 1'b1; jmp_target_i = 32'hFFFF_FFFC; end
            default: ;
         endcase
         if (inst_valid_o && inst_ready_i && busy && !model_fault) begin
            if (jmp_flag_i) tgt = jmp_target_i;
            else if (branch_taken_i) tgt = branch_target_i;
            else tgt = exp_pc + 32'd4;
            exp_cnt = exp_cnt + 32'd1;
            busy = 1'b0;
            if (tgt[1:0] != 2'b00) begin
               model_fault = 1'b1;
               fault_q.push_back('{fpc: tgt, pc: exp_pc, cnt: exp_cnt});
            end else begin
               exp_pc = tgt;
            end
         end
      end
      rst_prev = rst;
   end

   int checks = 0, failures = 0;
   inst_exp_t  cur;
   fault_exp_t fexp;
   bit valid_prev = 1'b0, fault_prev = 1'b0, rst_neg_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard queues.
   always @(negedge clk) begin
      if (rst) begin
         if (rst_neg_prev) begin
            chk("rst_req_valid", 32'(imem_req_valid_o), 32'd1);
            chk("rst_req_addr", imem_req_addr_o, RPC);
            chk("rst_pc", pc_o, RPC);
            chk("rst_inst", inst_o, 32'd0);
            chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
            chk("rst_fault", 32'(fault_o), 32'd0);
            chk("rst_fault_pc", fault_pc_o, 32'd0);
            chk("rst_fetch_cnt", fetch_cnt_o, 32'd0);
         end
         valid_prev = 1'b0;
         fault_prev = 1'b0;
      end else begin
         if (imem_req_valid_o && imem_req_ready_i) begin
            chk("req_expected", 32'(req_q.size() != 0), 32'd1);
            if (req_q.size() != 0) chk("req_addr", imem_req_addr_o, req_q.pop_front());
         end
         if (inst_valid_o && !valid_prev) begin
            chk("inst_expected", 32'(inst_q.size() != 0), 32'd1);
            if (inst_q.size() != 0) begin
               cur = inst_q.pop_front();
               chk("inst", inst_o, cur.inst);
               chk("inst_pc", pc_o, cur.pc);
               chk("fetch_cnt", fetch_cnt_o, cur.cnt);
            end
         end else if (inst_valid_o) begin
            chk("inst_stable", inst_o, cur.inst);
            chk("pc_stable", pc_o, cur.pc);
         end
         if (inst_valid_o) chk("req_during_hold", 32'(imem_req_valid_o), 32'd0);
         if (fault_o && !fault_prev) begin
            chk("fault_expected", 32'(fault_q.size() != 0), 32'd1);
            if (fault_q.size() != 0) begin
               fexp = fault_q.pop_front();
               chk("fault_pc", fault_pc_o, fexp.fpc);
               chk("fault_pc_hold", pc_o, fexp.pc);
               chk("fault_cnt", fetch_cnt_o, fexp.cnt);
            end
         end
         if (fault_o) chk("fault_quiet", {30'd0, imem_req_valid_o, inst_valid_o}, 32'd0);
         valid_prev = inst_valid_o;
         fault_prev = fault_o;
      end
      rst_neg_prev = rst;
   end

   task automatic do_reset(input int n);
      @(posedge clk); #1 rst = 1'b1;
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_cnt(input logic [31:0] target);
      int n = 0;
      while (fetch_cnt_o < target) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            $display("FAIL wait_cnt_timeout actual=%0d required=%0d", fetch_cnt_o, target);
            $fatal(1, "fetch count did not advance");
         end
      end
   endtask

   task automatic wait_fault();
      int n = 0;
      while (!fault_o) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            $display("FAIL wait_fault_timeout actual=0 required=1");
            $fatal(1, "fault did not occur");
         end
      end
   endtask

   task automatic wait_req();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            $display("FAIL wait_req_timeout actual=0 required=1");
            $fatal(1, "request never accepted");
         end
      end while (!(imem_req_valid_o && imem_req_ready_i));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Sequential NOP fetch, then a 5-cycle decoder stall.
      wait_cnt(3);
      min_hold = 5;
      wait_cnt(5);
      min_hold = 0;

      // Jump beats branch, then jump to the top of the address space and wrap.
      mode = 1; wait_cnt(6);
      mode = 3; wait_cnt(7);
      mode = 5; wait_cnt(8);
      mode = 3; wait_cnt(10);

      // Randomized traffic with aligned redirects.
      data_nop = 1'b0; ready_pct = 60; accept_pct = 60; max_delay = 4; mode = 0;
      wait_cnt(50);

      // Misaligned branch target.
      mode = 2;
      wait_fault();
      repeat (5) @(negedge clk);
      data_nop = 1'b1; ready_pct = 100; accept_pct = 100; max_delay = 1; mode = 3;
      do_reset(2);

      // Access fault on the third fetch (PC RESET_PC+8).
      wait_cnt(2);
      err_pct = 100;
      wait_fault();
      err_pct = 0;
      repeat (3) @(negedge clk);
      do_reset(2);

      // Reset while waiting, then a stale response right after release.
      min_delay = 4; max_delay = 4;
      wait_req();
      stale_en = 1'b1;
      do_reset(2);
      min_delay = 1; max_delay = 1;
      wait_cnt(2);
      stale_en = 1'b0;

      data_nop = 1'b0; ready_pct = 70; accept_pct = 70; max_delay = 3; mode = 0;
      wait_cnt(30);
      repeat (5) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
